// File: rtl/trap_pkg.sv
// Shared definitions for the trapezoid filter parameter path.
// Holds the frame header constant, the loader FSM state type, the
// value-byte-count helper and the parameter index map that the
// trapezoid filter decodes on selParam.
package trap_pkg;

  // First byte of every parameter frame.
  localparam logic [7:0] TRAP_HDR = 8'hA5;

  // Number of implemented parameter addresses in the filter.
  localparam int unsigned TRAP_NUM_PARAMS = 4;

  // Parameter indices shared with the trapezoid filter.
  localparam int unsigned TRAP_IDX_K    = 0;  // rise length
  localparam int unsigned TRAP_IDX_L    = 1;  // rise + flat-top length
  localparam int unsigned TRAP_IDX_M    = 2;  // pole-zero / decay compensation
  localparam int unsigned TRAP_IDX_GAIN = 3;  // output scaling

  // Loader FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StVal,
    StCsum,
    StWrite,
    StErr
  } trap_state_e;

  // Number of bytes needed to carry an nbits-wide value.
  function automatic int unsigned trap_nbytes(int unsigned nbits);
    return (nbits + 7) / 8;
  endfunction

endpackage

// File: rtl/trap_param_loader.sv
// Byte-stream parameter programmer for the trapezoid filter.
// Decodes frames  A5 | ADDR | value bytes (MSB first) | CSUM  into one
// single-cycle write on selParam/params. CSUM is the XOR of ADDR and the
// value bytes. Bad checksum, out-of-range address or an inter-byte gap
// longer than TIMEOUT cycles produce a frame_err pulse and no write.
//
// Ports:
//   clk       system clock, rising edge
//   clr       asynchronous active-low reset
//   rx_data   incoming byte
//   rx_valid  rx_data is valid
//   rx_ready  loader accepts a byte this cycle (low for one bubble per frame)
//   params    registered parameter value, held until the next write
//   selParam  registered parameter address, held until the next write
//   param_we  one-cycle write strobe
//   frame_ok  one-cycle pulse: frame accepted and written
//   frame_err one-cycle pulse: frame rejected
module trap_param_loader
  import trap_pkg::*;
#(
  parameter int unsigned Nbits      = 14,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_PARAMS = TRAP_NUM_PARAMS,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [Nbits-1:0]      params,
  output logic [ADDR_WIDTH-1:0] selParam,
  output logic                  param_we,
  output logic                  frame_ok,
  output logic                  frame_err
);

  localparam int unsigned NB   = trap_nbytes(Nbits);
  localparam int unsigned ShW  = 8 * NB;
  localparam int unsigned CntW = $clog2(NB + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  trap_state_e           state_q, state_d;
  logic [7:0]            addr_q, addr_d;
  logic [ShW-1:0]        shift_q, shift_d;
  logic [7:0]            xor_q, xor_d;
  logic [CntW-1:0]       bcnt_q, bcnt_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic [Nbits-1:0]      params_q, params_d;
  logic [ADDR_WIDTH-1:0] sel_q, sel_d;
  logic                  we_q, we_d;
  logic                  ok_q, ok_d;
  logic                  err_q, err_d;
  logic                  ready_q, ready_d;
  logic                  accept;

  assign accept = rx_valid && ready_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    shift_d  = shift_q;
    xor_d    = xor_q;
    bcnt_d   = bcnt_q;
    tmo_d    = tmo_q;
    params_d = params_q;
    sel_d    = sel_q;
    we_d     = 1'b0;
    ok_d     = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        xor_d  = '0;
        bcnt_d = '0;
        tmo_d  = '0;
        if (accept && rx_data == TRAP_HDR) state_d = StAddr;
      end
      StAddr: begin
        if (accept) begin
          addr_d  = rx_data;
          xor_d   = xor_q ^ rx_data;
          bcnt_d  = '0;
          state_d = StVal;
        end
      end
      StVal: begin
        if (accept) begin
          // Cast drops the oldest byte; only the low Nbits are ever used.
          shift_d = ShW'({shift_q, rx_data});
          xor_d   = xor_q ^ rx_data;
          if (bcnt_q == CntW'(NB - 1)) begin
            state_d = StCsum;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      StCsum: begin
        if (accept) begin
          // Range check uses the full address byte, not the truncated one.
          if (rx_data == xor_q && 32'(addr_q) < NUM_PARAMS) begin
            params_d = shift_q[Nbits-1:0];
            sel_d    = addr_q[ADDR_WIDTH-1:0];
            we_d     = 1'b1;
            ok_d     = 1'b1;
            state_d  = StWrite;
          end else begin
            err_d   = 1'b1;
            state_d = StErr;
          end
        end
      end
      StWrite, StErr: state_d = StIdle;
      default:        state_d = StIdle;
    endcase

    // Inter-byte gap watchdog while inside a frame; an accepted byte wins.
    if (state_q inside {StAddr, StVal, StCsum}) begin
      if (accept) begin
        tmo_d = '0;
      end else if (tmo_q == TmoW'(TIMEOUT)) begin
        tmo_d   = '0;
        err_d   = 1'b1;
        state_d = StErr;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    // Registered so that ready is low during reset and during the bubble.
    ready_d = state_d inside {StIdle, StAddr, StVal, StCsum};
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      shift_q  <= '0;
      xor_q    <= '0;
      bcnt_q   <= '0;
      tmo_q    <= '0;
      params_q <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      shift_q  <= shift_d;
      xor_q    <= xor_d;
      bcnt_q   <= bcnt_d;
      tmo_q    <= tmo_d;
      params_q <= params_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  assign rx_ready  = ready_q;
  assign params    = params_q;
  assign selParam  = sel_q;
  assign param_we  = we_q;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_trap_param_loader.sv
// Scoreboard bench for trap_param_loader: frame senders push the expected
// outcome of each frame; a monitor pops and checks whenever a pulse appears.
module tb_trap_param_loader;

  localparam int unsigned NBITS = 14;
  localparam int unsigned NPAR  = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [13:0] params;
  logic [7:0]  selParam;
  logic        param_we;
  logic        frame_ok;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          ok;
    logic [7:0]  addr;
    logic [13:0] val;
    longint      due;   // 0: any time
  } exp_t;

  exp_t        exp_q[$];
  logic [13:0] mdl_params = '0;
  logic [7:0]  mdl_sel = '0;

  trap_param_loader #(
    .Nbits     (NBITS),
    .ADDR_WIDTH(8),
    .NUM_PARAMS(NPAR),
    .TIMEOUT   (1024)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .params   (params),
    .selParam (selParam),
    .param_we (param_we),
    .frame_ok (frame_ok),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sampled just after the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (param_we || frame_ok || frame_err) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {61'd0, param_we, frame_ok, frame_err}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        if (e.due != 0) chk("latency", 64'($time - 1), 64'(e.due));
        chk("frame_ok", 64'(frame_ok), 64'(e.ok));
        chk("frame_err", 64'(frame_err), 64'(!e.ok));
        chk("param_we", 64'(param_we), 64'(e.ok));
        if (e.ok) begin
          mdl_params = e.val;
          mdl_sel    = e.addr;
        end
        chk("params", 64'(params), 64'(mdl_params));
        chk("selParam", 64'(selParam), 64'(mdl_sel));
      end
    end
  end

  function automatic logic [7:0] csum_of(input logic [7:0] addr, input logic [15:0] v);
    return addr ^ v[15:8] ^ v[7:0];
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] b, output int waits);
    waits = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!rx_ready) chk("send_ready_timeout", 64'(rx_ready), 64'd1);
    @(negedge clk);
  endtask

  task automatic gap(input int gmax);
    int g;
    g = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
    if (g > 0) begin
      rx_valid = 1'b0;
      repeat (g) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] addr, input logic [15:0] v,
                            input logic [7:0] cs, input int gmax,
                            output int hdr_waits, output int body_waits);
    exp_t e;
    int   w;
    body_waits = 0;
    send_byte(8'hA5, hdr_waits);
    gap(gmax);
    send_byte(addr, w);     body_waits += w; gap(gmax);
    send_byte(v[15:8], w);  body_waits += w; gap(gmax);
    send_byte(v[7:0], w);   body_waits += w; gap(gmax);
    send_byte(cs, w);       body_waits += w;
    e.ok   = (cs == csum_of(addr, v)) && (int'(addr) < NPAR);
    e.addr = addr;
    e.val  = 14'(v % (1 << NBITS));
    e.due  = longint'($time);
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    rx_valid = 1'b0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
    chk({tag, "_params"}, 64'(params), 64'd0);
    chk({tag, "_selParam"}, 64'(selParam), 64'd0);
    chk({tag, "_pulses"}, {61'd0, param_we, frame_ok, frame_err}, 64'd0);
  endtask

  initial begin
    int hw, bw, hw2, bw2, w;
    logic [7:0]  a, cs, gb;
    logic [15:0] v;

    // Reset state.
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    clr = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(rx_ready), 64'd1);

    // Directed frames.
    send_frame(8'h02, 16'h1234, 8'h24, 0, hw, bw);   // good
    drain();
    send_frame(8'h02, 16'h1234, 8'h25, 0, hw, bw);   // bad checksum
    drain();
    send_frame(8'h07, 16'h0001, 8'h06, 0, hw, bw);   // address out of range
    drain();
    send_frame(8'h01, 16'hFFFF, 8'h01, 0, hw, bw);   // truncation to 0x3FFF
    drain();
    chk("trunc_params", 64'(params), 64'h3FFF);

    // Timeout: nothing may fire early, then one error, then resync.
    send_byte(8'hA5, w);
    send_byte(8'h02, w);
    send_byte(8'h12, w);
    rx_valid = 1'b0;
    repeat (1000) @(negedge clk);
    begin
      exp_t e;
      e.ok = 1'b0; e.addr = '0; e.val = '0; e.due = 0;
      exp_q.push_back(e);
    end
    drain();
    send_byte(8'h00, w);
    send_byte(8'h33, w);
    send_frame(8'h03, 16'h0ABC, csum_of(8'h03, 16'h0ABC), 0, hw, bw);
    drain();
    chk("resync_params", 64'(params), 64'h0ABC);

    // Randomized frames with garbage, gaps and occasional corruption.
    for (int i = 0; i < 40; i++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        gb = 8'($urandom_range(0, 255));
        if (gb == 8'hA5) gb = 8'h00;
        send_byte(gb, w);
      end
      a  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
      v  = 16'($urandom);
      cs = csum_of(a, v);
      if ($urandom_range(0, 4) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
      send_frame(a, v, cs, 2, hw, bw);
    end
    drain();

    // Reset mid-frame: partial frame discarded, no pulses.
    send_byte(8'hA5, w);
    send_byte(8'h02, w);
    rx_valid = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    exp_q.delete();
    mdl_params = '0;
    mdl_sel    = '0;
    #1;
    chk_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk("ready_after_midreset", 64'(rx_ready), 64'd1);

    // Back-to-back frames with rx_valid held: exactly one bubble between.
    send_frame(8'h01, 16'h0555, csum_of(8'h01, 16'h0555), 0, hw, bw);
    send_frame(8'h02, 16'h2AAA, csum_of(8'h02, 16'h2AAA), 0, hw2, bw2);
    chk("b2b_first_hdr_wait", 64'(hw), 64'd0);
    chk("b2b_bubble", 64'(hw2), 64'd1);
    chk("b2b_body_waits", 64'(bw + bw2), 64'd0);
    drain();
    chk("b2b_params", 64'(params), 64'h2AAA);
    chk("b2b_selParam", 64'(selParam), 64'h02);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_param_loader.md
# trap_param_loader

Byte-stream parameter programmer for the `trapezoid` filter parameter store. It receives framed bytes from the host link (UART/SPI byte receiver) and decodes each frame into an (address, value) pair. For every valid frame it issues exactly one single-cycle write on the `selParam`/`params` port pair that the filter consumes. Malformed frames are rejected with an error pulse, and the filter parameters are left untouched.

## Interface
- `Nbits`, 14: width of a filter parameter value.
- `ADDR_WIDTH`, 8: width of `selParam`. Must be ≤ 8.
- `NUM_PARAMS`, 4: number of implemented parameter addresses. Valid addresses are 0..NUM_PARAMS-1.
- `TIMEOUT`, 1024: maximum idle gap, in cycles, between bytes inside a frame.
- `clk`  in  1  system clock. All logic is on the rising edge.
- `clr`  in  1  reset. Asynchronous, active-low.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader can accept a byte.
- `params`  out  Nbits  parameter value to write.
- `selParam`  out  ADDR_WIDTH  parameter address.
- `param_we`  out  1  one-cycle write strobe for `params`/`selParam`.
- `frame_ok`  out  1  one-cycle pulse: frame accepted and written.
- `frame_err`  out  1  one-cycle pulse: frame rejected.

## Operation
- Frame format: `0xA5` header, then ADDR byte, then NB = (Nbits+7)/8 value bytes (MSB first), then CSUM byte.
- CSUM = XOR of the ADDR byte and all value bytes. The header is not included.
- A byte is accepted on any cycle with `rx_valid && rx_ready`.
- States and transitions:
  - IDLE: `0xA5` → ADDR. Any other byte is discarded silently.
  - ADDR: latch the byte → VAL, with byte counter = 0.
  - VAL: shift in the byte. After NB bytes → CSUM.
  - CSUM: compare the byte with the running XOR.
    - If the checksum matches and ADDR < NUM_PARAMS → WRITE.
    - Otherwise → ERR.
  - WRITE: 1 cycle, then → IDLE.
  - ERR: 1 cycle, then → IDLE.
- Value assembly: a shift register of 8·NB bits, truncated to the low Nbits. Unused upper bits of the first value byte are ignored. They are still included in the checksum.
- Address: the ADDR byte is truncated to ADDR_WIDTH for `selParam`. The range check uses the full 8-bit byte.
- A header byte (`0xA5`) received mid-frame is treated as data. No resynchronisation happens until a timeout or an error.
- Timeout:
  - A cycle counter runs in ADDR, VAL and CSUM. It clears on every accepted byte.
  - When it reaches TIMEOUT, the FSM goes to ERR (`frame_err` pulses), then to IDLE.

## Timing
- Reset values: `rx_ready`=0 while `clr` is low, and 1 in the first cycle after release. `params`=0, `selParam`=0, `param_we`=0, `frame_ok`=0, `frame_err`=0. FSM is in IDLE. Counters and XOR accumulator are 0.
- `rx_ready` is 1 in IDLE, ADDR, VAL and CSUM. It is 0 in WRITE and ERR, so one bubble follows each frame.
- Latency: CSUM byte accepted at cycle N → `param_we`, `frame_ok` (or `frame_err`) high during cycle N+1 only.
- `params`/`selParam` are registered. They are valid in the `param_we` cycle and hold their value until the next write.
- A back-to-back frame header may be accepted at cycle N+2.
- Reset asserted mid-frame: the partial frame is discarded. No write and no error pulse occur.
- Throughput: one byte per cycle. A frame is consumed in NB+3 accepted bytes plus one bubble.

## Structure
- Shared package `trap_pkg`:
  - Header constant `TRAP_HDR = 8'hA5`.
  - State enum.
  - Function `trap_nbytes(Nbits)`.
  - Default NUM_PARAMS and the parameter index constants shared with `trapezoid`.
- Single module, no sub-module required. The timeout counter is inline, with width $clog2(TIMEOUT+1).

## Test plan
- Good frame: bytes A5 02 12 34 24 → one `param_we` with `selParam`=2 and `params`=0x1234, `frame_ok` pulse, no `frame_err`.
- Bad checksum: A5 02 12 34 25 → `frame_err` pulse. `param_we` never asserts. `params`/`selParam` keep their previous values.
- Address out of range: A5 07 00 01 06 with NUM_PARAMS=4 → `frame_err`, no write.
- Truncation: A5 01 FF FF 01 → `params`=0x3FFF, `selParam`=1, `frame_ok`.
- Timeout and resync: A5 02 12, then no `rx_valid` for 1024 cycles → `frame_err`. Then garbage 00 33 followed by a good frame → exactly one correct write.
- Reset mid-frame plus back-to-back frames:
  - Assert `clr` after A5 02 → all outputs 0, no pulses.
  - Then two good frames sent with `rx_valid` held high → two writes, with exactly one `rx_ready`-low bubble between them.
